// File: rtl/l2_writeback_queue.sv
// L2 victim writeback queue: a circular FIFO of dirty lines drained to memory
// as fixed-length AXI write bursts, with a snoop port for the fill path.
module l2_writeback_queue #(
   parameter int DEPTH     = 4,
   parameter int LINE_BITS = 512
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wb_enqueue,
   input  logic [25:0]          wb_line_address,
   input  logic [LINE_BITS-1:0] wb_line_data,
   output logic                 wb_full,
   output logic                 wb_empty,
   input  logic [25:0]          snoop_address,
   output logic                 snoop_hit,
   output logic [31:0]          axi_awaddr,
   output logic [7:0]           axi_awlen,
   output logic                 axi_awvalid,
   input  logic                 axi_awready,
   output logic [31:0]          axi_wdata,
   output logic                 axi_wlast,
   output logic                 axi_wvalid,
   input  logic                 axi_wready,
   input  logic                 axi_bvalid,
   output logic                 axi_bready,
   output logic                 wb_overflow
);

   localparam int BEAT_BITS = 32;
   localparam int BEATS     = LINE_BITS / BEAT_BITS;
   localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W     = PTR_W + 1;
   localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     r_tail;
   logic [CNT_W-1:0]     r_count;
   logic [BEAT_W-1:0]    r_beat;
   logic                 r_overflow;
   logic [25:0]          r_addr [DEPTH];
   logic [LINE_BITS-1:0] r_data [DEPTH];

   logic                 w_push;
   logic                 w_pop;

   assign wb_full     = (r_count == CNT_W'(DEPTH));
   assign wb_empty    = (r_count == '0);
   assign wb_overflow = r_overflow;

   // A pop while full frees the slot only on the next cycle, so the push
   // decision looks at the registered full flag alone.
   assign w_push = wb_enqueue && !wb_full;
   assign w_pop  = (r_state == ST_RESP) && axi_bvalid;

   // NOTE: line storage is deliberately left out of reset; validity comes
   // from head/count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= wb_line_address;
         r_data[r_tail] <= wb_line_data;
      end
   end

   // NOTE: every flop below uses non-blocking assignment so all updates see
   // the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_beat     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (wb_enqueue && wb_full) begin
            r_overflow <= 1'b1;
         end
         if ((r_state == ST_ADDR) && axi_awready) begin
            r_beat <= '0;
         end else if ((r_state == ST_DATA) && axi_wready) begin
            r_beat <= r_beat + BEAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every output of this block gets a default first so that no path
   // through the case statement can infer a latch.
   always_comb begin
      w_next_state = r_state;
      axi_awvalid  = 1'b0;
      axi_awaddr   = '0;
      axi_awlen    = '0;
      axi_wvalid   = 1'b0;
      axi_wdata    = '0;
      axi_wlast    = 1'b0;
      axi_bready   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!wb_empty) begin
               w_next_state = ST_ADDR;
            end
         end
         ST_ADDR: begin
            axi_awvalid = 1'b1;
            axi_awaddr  = {r_addr[r_head], 6'b0};
            axi_awlen   = 8'(BEATS - 1);
            if (axi_awready) begin
               w_next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            axi_wvalid = 1'b1;
            axi_wdata  = r_data[r_head][32'(r_beat) * BEAT_BITS +: BEAT_BITS];
            axi_wlast  = (r_beat == BEAT_W'(BEATS - 1));
            if (axi_wready && axi_wlast) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            axi_bready = 1'b1;
            if (axi_bvalid) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // An entry is live when its distance from head is below count; the head
   // stays live through its whole burst until the response pops it.
   always_comb begin
      snoop_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, PTR_W'(i) - r_head} < r_count) && (r_addr[i] == snoop_address)) begin
            snoop_hit = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_l2_writeback_queue.sv
// Self-checking bench for l2_writeback_queue: a vector table for queue status,
// then directed and random traffic checked against a queue-level model.
module tb_l2_writeback_queue;

   localparam int DEPTH = 4;
   localparam int LB    = 512;
   localparam int BEATS = LB / 32;

   logic          clk;
   logic          reset_n;
   logic          wb_enqueue;
   logic [25:0]   wb_line_address;
   logic [LB-1:0] wb_line_data;
   logic          wb_full;
   logic          wb_empty;
   logic [25:0]   snoop_address;
   logic          snoop_hit;
   logic [31:0]   axi_awaddr;
   logic [7:0]    axi_awlen;
   logic          axi_awvalid;
   logic          axi_awready;
   logic [31:0]   axi_wdata;
   logic          axi_wlast;
   logic          axi_wvalid;
   logic          axi_wready;
   logic          axi_bvalid;
   logic          axi_bready;
   logic          wb_overflow;

   l2_writeback_queue #(.DEPTH(DEPTH), .LINE_BITS(LB)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .wb_enqueue      (wb_enqueue),
      .wb_line_address (wb_line_address),
      .wb_line_data    (wb_line_data),
      .wb_full         (wb_full),
      .wb_empty        (wb_empty),
      .snoop_address   (snoop_address),
      .snoop_hit       (snoop_hit),
      .axi_awaddr      (axi_awaddr),
      .axi_awlen       (axi_awlen),
      .axi_awvalid     (axi_awvalid),
      .axi_awready     (axi_awready),
      .axi_wdata       (axi_wdata),
      .axi_wlast       (axi_wlast),
      .axi_wvalid      (axi_wvalid),
      .axi_wready      (axi_wready),
      .axi_bvalid      (axi_bvalid),
      .axi_bready      (axi_bready),
      .wb_overflow     (wb_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [25:0]   addr;
      logic [LB-1:0] data;
   } line_t;

   typedef struct {
      logic        enq;
      logic [25:0] addr;
      logic [25:0] snoop;
      logic        full;
      logic        empty;
      logic        hit;
      logic        ovf;
   } vec_t;

   int    checks;
   int    errors;
   int    pops;
   int    beat;
   bit    aw_done;
   bit    ovf_m;
   line_t mq[$];

   // Values applied to the DUT at the next falling edge.
   logic          n_enq;
   logic [25:0]   n_addr;
   logic [LB-1:0] n_data;
   logic [25:0]   n_snoop;
   logic          n_awready;
   logic          n_wready;
   logic          n_bvalid;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [LB-1:0] rand_line();
      logic [LB-1:0] l;
      for (int i = 0; i < BEATS; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic check_reset_outs();
      check("rst_awvalid", axi_awvalid, 0);
      check("rst_wvalid", axi_wvalid, 0);
      check("rst_wlast", axi_wlast, 0);
      check("rst_bready", axi_bready, 0);
      check("rst_awaddr", axi_awaddr, 0);
      check("rst_awlen", axi_awlen, 0);
      check("rst_wdata", axi_wdata, 0);
      check("rst_empty", wb_empty, 1);
      check("rst_full", wb_full, 0);
      check("rst_snoop_hit", snoop_hit, 0);
      check("rst_overflow", wb_overflow, 0);
   endtask

   task automatic idle_inputs();
      n_enq = 0; n_addr = '0; n_data = '0; n_snoop = '0;
      n_awready = 0; n_wready = 0; n_bvalid = 0;
   endtask

   // Compare current outputs against the model, then advance the model by the
   // handshakes and enqueue that the coming rising edge will take.
   task automatic observe();
      logic hit_exp;
      int   sz;
      sz = mq.size();
      check("wb_full", wb_full, sz == DEPTH);
      check("wb_empty", wb_empty, sz == 0);
      check("wb_overflow", wb_overflow, ovf_m);
      hit_exp = 0;
      foreach (mq[i]) if (mq[i].addr == snoop_address) hit_exp = 1;
      check("snoop_hit", snoop_hit, hit_exp);
      if (axi_awvalid) begin
         if (sz == 0 || aw_done) check("aw_unexpected", axi_awvalid, 0);
         else begin
            check("awaddr", axi_awaddr, {mq[0].addr, 6'b0});
            check("awlen", axi_awlen, BEATS - 1);
         end
      end
      if (axi_wvalid) begin
         if (sz == 0 || !aw_done || beat >= BEATS) check("w_unexpected", axi_wvalid, 0);
         else begin
            check("wdata", axi_wdata, mq[0].data[beat*32 +: 32]);
            check("wlast", axi_wlast, beat == BEATS - 1);
         end
      end
      if (axi_bready) check("resp_beats", beat, BEATS);

      if (wb_enqueue && sz == DEPTH) ovf_m = 1;
      if (axi_awvalid && axi_awready && sz > 0 && !aw_done) begin
         aw_done = 1;
         beat    = 0;
      end
      if (axi_wvalid && axi_wready && aw_done) beat++;
      if (axi_bready && axi_bvalid && sz > 0) begin
         void'(mq.pop_front());
         aw_done = 0;
         beat    = 0;
         pops++;
      end
      if (wb_enqueue && sz < DEPTH) mq.push_back('{wb_line_address, wb_line_data});
   endtask

   task automatic cycle();
      @(negedge clk);
      wb_enqueue      = n_enq;
      wb_line_address = n_addr;
      wb_line_data    = n_data;
      snoop_address   = n_snoop;
      axi_awready     = n_awready;
      axi_wready      = n_wready;
      axi_bvalid      = n_bvalid;
      #1;
      observe();
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset_n = 0;
      wb_enqueue = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
      #1;
      check_reset_outs();
      mq.delete();
      beat = 0; aw_done = 0; ovf_m = 0; pops = 0;
      @(negedge clk);
      reset_n = 1;
   endtask

   task automatic drain(input int bound);
      n_enq = 0; n_awready = 1; n_wready = 1; n_bvalid = 1;
      for (int k = 0; k < bound && mq.size() != 0; k++) cycle();
      check("drain_timeout", mq.size(), 0);
      cycle();
      check("drained_empty", wb_empty, 1);
   endtask

   vec_t tbl[7];
   logic [LB-1:0] idx_line;
   logic [25:0]   pool[8];
   int            wcount;

   initial begin
      checks = 0; errors = 0; pops = 0; beat = 0; aw_done = 0; ovf_m = 0;
      idle_inputs();
      reset_n = 0;
      wb_enqueue = 0; wb_line_address = '0; wb_line_data = '0; snoop_address = '0;
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
      #1;
      check_reset_outs();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1;

      // Queue status table with the memory side stalled (awready low).
      tbl[0] = '{1'b0, 26'h10, 26'h10, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 26'h10, 26'h10, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 26'h20, 26'h30, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 26'h30, 26'h30, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 26'h40, 26'h20, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 26'h50, 26'h50, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 26'h00, 26'h10, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         wb_enqueue      = tbl[i].enq;
         wb_line_address = tbl[i].addr;
         snoop_address   = tbl[i].snoop;
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_full", i), wb_full, tbl[i].full);
         check($sformatf("tbl%0d_empty", i), wb_empty, tbl[i].empty);
         check($sformatf("tbl%0d_hit", i), snoop_hit, tbl[i].hit);
         check($sformatf("tbl%0d_ovf", i), wb_overflow, tbl[i].ovf);
      end

      // Single line, always-ready memory; latency and address format.
      do_reset();
      for (int i = 0; i < BEATS; i++) idx_line[i*32 +: 32] = 32'(i);
      n_enq = 1; n_addr = 26'h0000123; n_data = idx_line;
      n_awready = 1; n_wready = 1; n_bvalid = 1;
      cycle();
      n_enq = 0;
      cycle();
      check("lat_idle_awvalid", axi_awvalid, 0);
      cycle();
      check("lat_awvalid", axi_awvalid, 1);
      check("awaddr_48c0", axi_awaddr, 32'h000048C0);
      check("awlen_15", axi_awlen, 8'd15);
      wcount = 0;
      for (int k = 0; k < 40 && mq.size() != 0; k++) begin
         cycle();
         if (axi_wvalid && axi_wready) begin
            check("idx_wdata", axi_wdata, wcount);
            check("idx_wlast", axi_wlast, wcount == BEATS - 1);
            wcount++;
         end
      end
      check("idx_beats", wcount, BEATS);
      cycle();
      check("idx_empty", wb_empty, 1);
      check("idx_pops", pops, 1);

      // Five back-to-back enqueues against a stalled address channel.
      do_reset();
      n_awready = 0; n_wready = 1; n_bvalid = 1;
      for (int i = 0; i < 5; i++) begin
         n_enq = 1; n_addr = 26'h100 + 26'(i); n_data = rand_line();
         cycle();
      end
      n_enq = 0;
      cycle();
      check("ovf_full", wb_full, 1);
      check("ovf_flag", wb_overflow, 1);
      drain(400);
      check("ovf_pops", pops, 4);
      check("ovf_sticky", wb_overflow, 1);

      // Write-ready toggling every cycle.
      do_reset();
      n_enq = 1; n_addr = 26'h2AB; n_data = rand_line();
      n_awready = 1; n_wready = 0; n_bvalid = 1;
      cycle();
      n_enq = 0;
      wcount = 0;
      for (int k = 0; k < 80 && mq.size() != 0; k++) begin
         n_wready = k[0];
         cycle();
         if (axi_wvalid && axi_wready) wcount++;
      end
      check("toggle_beats", wcount, BEATS);
      check("toggle_pops", pops, 1);

      // Snoop across a pop.
      do_reset();
      n_awready = 0; n_wready = 1; n_bvalid = 1;
      n_enq = 1; n_addr = 26'h0AAAAAA; n_data = rand_line(); cycle();
      n_enq = 1; n_addr = 26'h0BBBBBB; n_data = rand_line(); cycle();
      n_enq = 0; n_snoop = 26'h0AAAAAA; cycle();
      check("snoop_a_queued", snoop_hit, 1);
      n_awready = 1;
      for (int k = 0; k < 60 && pops == 0; k++) cycle();
      check("snoop_pop_timeout", pops, 1);
      cycle();
      check("snoop_a_popped", snoop_hit, 0);
      n_snoop = 26'h0BBBBBB; cycle();
      check("snoop_b_still", snoop_hit, 1);
      drain(100);

      // Enqueue in the same cycle as a pop with DEPTH-1 entries, six lines total.
      do_reset();
      n_awready = 0; n_wready = 1; n_bvalid = 0;
      for (int i = 0; i < 3; i++) begin
         n_enq = 1; n_addr = 26'h300 + 26'(i); n_data = rand_line(); cycle();
      end
      n_enq = 0; n_awready = 1;
      for (int k = 0; k < 100 && !axi_bready; k++) cycle();
      check("resp_reached", axi_bready, 1);
      n_enq = 1; n_addr = 26'h303; n_data = rand_line(); n_bvalid = 1; cycle();
      n_enq = 0; n_bvalid = 0; cycle();
      check("pushpop_not_full", wb_full, 0);
      check("pushpop_not_empty", wb_empty, 0);
      n_enq = 1; n_addr = 26'h304; n_data = rand_line(); cycle();
      n_enq = 0; cycle();
      check("pushpop_now_full", wb_full, 1);
      n_bvalid = 1;
      for (int k = 0; k < 100 && mq.size() == DEPTH; k++) cycle();
      n_enq = 1; n_addr = 26'h305; n_data = rand_line(); cycle();
      drain(400);
      check("wrap_pops", pops, 6);
      check("wrap_no_ovf", wb_overflow, 0);

      // Reset in the middle of a data burst.
      do_reset();
      n_enq = 1; n_addr = 26'h3C0; n_data = rand_line();
      n_awready = 1; n_wready = 1; n_bvalid = 1;
      cycle();
      n_enq = 0;
      for (int k = 0; k < 40 && !(aw_done && beat == 7); k++) cycle();
      check("beat7_reached", beat, 7);
      reset_n = 0;
      #1;
      check_reset_outs();
      mq.delete();
      beat = 0; aw_done = 0; ovf_m = 0; pops = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1;
      wcount = 0;
      for (int k = 0; k < 30; k++) begin
         cycle();
         if (axi_wvalid || axi_awvalid) wcount++;
      end
      check("no_beats_after_reset", wcount, 0);

      // Random traffic against the model.
      do_reset();
      foreach (pool[i]) pool[i] = 26'($urandom);
      for (int k = 0; k < 3000; k++) begin
         n_enq     = ($urandom_range(99) < 35);
         n_addr    = pool[$urandom_range(7)];
         n_data    = rand_line();
         n_snoop   = ($urandom_range(3) == 0) ? 26'($urandom) : pool[$urandom_range(7)];
         n_awready = ($urandom_range(3) != 0);
         n_wready  = ($urandom_range(3) != 0);
         n_bvalid  = ($urandom_range(2) != 0);
         cycle();
      end
      drain(1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/l2_writeback_queue.md
L2_WRITEBACK_QUEUE -- requirements
Module: l2_writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered victim lines (power of 2, >=2).
REQ-002 SHALL have parameter LINE_BITS, default 512, cache line width; BEAT_BITS fixed at 32, BEATS = LINE_BITS/32 = 16.
REQ-003 SHALL have port clk, input, 1, sole clock; all flops rising-edge.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port wb_enqueue, input, 1, evicted dirty line presented this cycle.
REQ-006 SHALL have port wb_line_address, input, 26, line address of victim (byte address bits 31:6).
REQ-007 SHALL have port wb_line_data, input, LINE_BITS, victim line data.
REQ-008 SHALL have port wb_full, output, 1, no free entry.
REQ-009 SHALL have port wb_empty, output, 1, no entry buffered or in flight.
REQ-010 SHALL have port snoop_address, input, 26, line address checked by fill path.
REQ-011 SHALL have port snoop_hit, output, 1, snoop_address matches a valid entry.
REQ-012 SHALL have ports axi_awaddr out 32, axi_awlen out 8, axi_awvalid out 1, axi_awready in 1: write address channel.
REQ-013 SHALL have ports axi_wdata out 32, axi_wlast out 1, axi_wvalid out 1, axi_wready in 1: write data channel.
REQ-014 SHALL have ports axi_bvalid in 1, axi_bready out 1: write response channel.
REQ-015 SHALL have port wb_overflow, output, 1, sticky flag: enqueue attempted while full.

Function
REQ-016 SHALL store entries in a circular FIFO (head/tail pointers, count 0..DEPTH); wb_full = (count==DEPTH), wb_empty = (count==0), both combinational from registered state.
REQ-017 SHALL accept an enqueue iff wb_enqueue && !wb_full, writing address/data at tail, tail wraps DEPTH-1 -> 0.
REQ-018 SHALL discard wb_enqueue while wb_full (count/contents unchanged) and set wb_overflow next cycle, cleared only by reset.
REQ-019 SHALL, on same-cycle accepted enqueue and pop, leave count unchanged; a pop while full does not permit a same-cycle enqueue.
REQ-020 SHALL run a state machine IDLE, ADDR, DATA, RESP driving memory writes from the head entry only.
REQ-021 IDLE: if count!=0, next state ADDR; else stay.
REQ-022 ADDR: axi_awvalid=1, axi_awaddr={head address, 6'b0}, axi_awlen=BEATS-1 (8'd15); held stable until axi_awready; then DATA with beat counter=0.
REQ-023 DATA: axi_wvalid=1, axi_wdata=head data bits [beat*32 +: 32] (beat 0 = bits 31:0); beat increments on axi_wready; axi_wlast=1 iff beat==BEATS-1; on accepted last beat, next RESP.
REQ-024 RESP: axi_bready=1; on axi_bvalid pop head (head wraps), count decrements, next IDLE.
REQ-025 Minimum latency enqueue-into-empty to axi_awvalid SHALL be 2 cycles (enqueue edge, IDLE->ADDR edge).
REQ-026 axi_awvalid/axi_wvalid SHALL not deassert before handshake; data/address SHALL not change while valid and not ready.
REQ-027 snoop_hit SHALL be combinational: OR over all valid entries (including head in flight until popped) of address==snoop_address; entry being enqueued this cycle not included.
REQ-028 Head entry SHALL not be overwritten while in flight (guaranteed by REQ-017).

Reset
REQ-029 While reset_n low: state IDLE, head=tail=count=0, beat=0, wb_overflow=0, axi_awvalid=axi_wvalid=axi_wlast=axi_bready=0, axi_awaddr=axi_wdata=0, axi_awlen=0, wb_empty=1, wb_full=0, snoop_hit=0.
REQ-030 Reset asserted mid-burst SHALL abandon the transaction and drop all entries; entry storage need not be cleared.

Verification
REQ-031 Single enqueue addr 26'h0000123, data = beat index in each word, awready/wready/bvalid always 1 -> awaddr 32'h000048C0, awlen 15, 16 beats wdata 0..15, wlast on beat 15 only, wb_empty=1 after bvalid.
REQ-032 Enqueue 5 lines back-to-back with awready=0 -> first 4 accepted, wb_full=1 after 4th, wb_overflow=1, 5th never written to memory.
REQ-033 wready toggling 1,0 each cycle -> wdata stable across stalled cycles, exactly 16 accepted beats, order preserved.
REQ-034 Entries at addresses A, B queued; snoop A -> hit=1; after A's bvalid, snoop A -> 0, snoop B -> 1.
REQ-035 Enqueue during RESP pop at count=DEPTH-1 -> count stays DEPTH-1; 6 total lines drain in FIFO order with pointer wrap.
REQ-036 reset_n low at beat 7 of DATA -> all AXI valids 0 immediately, wb_empty=1, no further beats after release.
